// File: rtl/snl_game_engine.sv
// snl_game_engine: N-player Snakes and Ladders turn engine.
// LFSR dice, exact landing, fixed jump table, sticky winner.
module snl_game_engine #(
  parameter int NUM_PLAYERS = 4,
  parameter int BOARD_MAX = 100,
  parameter int POS_W = 7,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  localparam int PID_W = (NUM_PLAYERS < 2) ? 1 : $clog2(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         roll,
  output logic                         roll_ready,
  input  logic                         dice_ovr_en,
  input  logic [2:0]                   dice_ovr,
  output logic [2:0]                   dice_value,
  output logic [PID_W-1:0]             active_player,
  output logic                         move_done,
  output logic [PID_W-1:0]             move_player,
  output logic [NUM_PLAYERS*POS_W-1:0] positions,
  output logic                         game_over,
  output logic [PID_W-1:0]             winner_id
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLLED,
    S_COMMIT,
    S_OVER
  } state_t;

  state_t           state;
  logic [7:0]       lfsr;
  logic             lfsr_fb;
  logic [2:0]       dice_raw;
  logic [2:0]       dice_sel;
  logic             ovr_ok;
  logic             accept;
  logic             win;
  logic [PID_W-1:0] mover_id;
  logic [PID_W-1:0] next_player;
  logic [POS_W-1:0] pos_q [NUM_PLAYERS];
  logic [POS_W-1:0] cur_pos;
  logic [POS_W-1:0] target_d;
  logic [POS_W-1:0] target_q;
  logic [POS_W:0]   sum;

  function automatic logic [POS_W-1:0] jump(input logic [POS_W-1:0] sq);
    case (int'(sq))
      27:      jump = POS_W'(1);
      39:      jump = POS_W'(3);
      51:      jump = POS_W'(19);
      3:       jump = POS_W'(22);
      5:       jump = POS_W'(8);
      11:      jump = POS_W'(26);
      default: jump = sq;
    endcase
  endfunction

  assign lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign dice_raw = 3'(lfsr % 8'd6) + 3'd1;
  assign ovr_ok   = dice_ovr_en &&
                    (dice_ovr >= 3'd1) &&
                    (dice_ovr <= 3'd6);
  assign dice_sel = ovr_ok ? dice_ovr : dice_raw;

  assign roll_ready = (state == S_IDLE) && !reset;
  assign accept     = roll && roll_ready;

  // Overshoot keeps the square; the jump table is consulted once only.
  assign cur_pos  = pos_q[mover_id];
  assign sum      = {1'b0, cur_pos} + (POS_W+1)'(dice_value);
  assign target_d = (sum > (POS_W+1)'(BOARD_MAX)) ?
                    cur_pos : jump(sum[POS_W-1:0]);
  assign win      = (target_q == POS_W'(BOARD_MAX));

  assign next_player =
    (active_player == PID_W'(NUM_PLAYERS-1)) ?
    '0 : active_player + 1'b1;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pos
    assign positions[p*POS_W +: POS_W] = pos_q[p];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      lfsr          <= LFSR_SEED;
      dice_value    <= '0;
      mover_id      <= '0;
      target_q      <= '0;
      active_player <= '0;
      move_done     <= 1'b0;
      move_player   <= '0;
      game_over     <= 1'b0;
      winner_id     <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) pos_q[p] <= '0;
    end else begin
      lfsr      <= {lfsr[6:0], lfsr_fb};
      move_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            dice_value <= dice_sel;
            mover_id   <= active_player;
            state      <= S_ROLLED;
          end
        end
        S_ROLLED: begin
          target_q <= target_d;
          state    <= S_COMMIT;
        end
        S_COMMIT: begin
          pos_q[mover_id] <= target_q;
          move_done       <= 1'b1;
          move_player     <= mover_id;
          if (win || dice_value != 3'd6)
            active_player <= next_player;
          if (win) begin
            game_over <= 1'b1;
            winner_id <= mover_id;
            state     <= S_OVER;
          end else begin
            state <= S_IDLE;
          end
        end
        S_OVER: state <= S_OVER;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snl_game_engine.sv
// tb_snl_game_engine: directed checks of the snl_game_engine
// turn engine with hand-computed expectations.
module tb_snl_game_engine;

  localparam int NP = 4;
  localparam int PW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          roll;
  logic          roll_ready;
  logic          dice_ovr_en;
  logic [2:0]    dice_ovr;
  logic [2:0]    dice_value;
  logic [1:0]    active_player;
  logic          move_done;
  logic [1:0]    move_player;
  logic [NP*PW-1:0] positions;
  logic          game_over;
  logic [1:0]    winner_id;

  int total = 0;
  int bad = 0;
  int face_cnt [7];

  always #5 clk = ~clk;

  snl_game_engine dut (
    .clk           (clk),
    .reset         (reset),
    .roll          (roll),
    .roll_ready    (roll_ready),
    .dice_ovr_en   (dice_ovr_en),
    .dice_ovr      (dice_ovr),
    .dice_value    (dice_value),
    .active_player (active_player),
    .move_done     (move_done),
    .move_player   (move_player),
    .positions     (positions),
    .game_over     (game_over),
    .winner_id     (winner_id)
  );

  function automatic logic [31:0] pos_of(input int p);
    return 32'(positions[p*PW +: PW]);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // One move from request to the cycle after commit.
  // Negative expectations mean "do not check this field".
  task automatic do_roll(input string tag, input bit en,
                         input logic [2:0] d, input int who,
                         input int exp_dice, input int exp_pos,
                         input int exp_act);
    chk({tag, ".ready"}, 32'(roll_ready), 1);
    chk({tag, ".turn"}, 32'(active_player), who);
    roll = 1'b1;
    dice_ovr_en = en;
    dice_ovr = d;
    @(negedge clk);
    roll = 1'b0;
    dice_ovr_en = 1'b0;
    dice_ovr = 3'd0;
    if (exp_dice >= 0)
      chk({tag, ".dice"}, 32'(dice_value), exp_dice);
    else
      chk({tag, ".dice_rng"},
          32'(dice_value >= 3'd1 && dice_value <= 3'd6), 1);
    chk({tag, ".busy"}, 32'(roll_ready), 0);
    chk({tag, ".md_k1"}, 32'(move_done), 0);
    @(negedge clk);
    chk({tag, ".md_k2"}, 32'(move_done), 0);
    @(negedge clk);
    chk({tag, ".md_pulse"}, 32'(move_done), 1);
    chk({tag, ".mover"}, 32'(move_player), who);
    if (exp_pos >= 0)
      chk({tag, ".pos"}, pos_of(who), exp_pos);
    if (exp_act >= 0)
      chk({tag, ".act"}, 32'(active_player), exp_act);
    @(negedge clk);
    chk({tag, ".md_end"}, 32'(move_done), 0);
  endtask

  initial begin
    reset = 1'b1;
    roll = 1'b0;
    dice_ovr_en = 1'b0;
    dice_ovr = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(roll_ready), 0);
    chk("rst.pos", 32'(positions), 0);
    chk("rst.dice", 32'(dice_value), 0);
    chk("rst.act", 32'(active_player), 0);
    chk("rst.over", 32'(game_over), 0);
    chk("rst.win", 32'(winner_id), 0);
    chk("rst.md", 32'(move_done), 0);
    reset = 1'b0;
    #1;
    chk("rel.ready", 32'(roll_ready), 1);

    // Reset lands in the middle of a move.
    roll = 1'b1;
    dice_ovr_en = 1'b1;
    dice_ovr = 3'd3;
    @(negedge clk);
    roll = 1'b0;
    dice_ovr_en = 1'b0;
    chk("mid.dice_pre", 32'(dice_value), 3);
    reset = 1'b1;
    #1;
    chk("mid.dice", 32'(dice_value), 0);
    chk("mid.ready", 32'(roll_ready), 0);
    repeat (2) begin
      @(negedge clk);
      chk("mid.md", 32'(move_done), 0);
      chk("mid.pos", 32'(positions), 0);
    end
    reset = 1'b0;
    #1;
    chk("mid.rel_ready", 32'(roll_ready), 1);
    chk("mid.act", 32'(active_player), 0);

    // Ladders, rotation, extra turn and wrap.
    do_roll("ladder3", 1, 3'd3, 0, 3, 22, 1);
    do_roll("ladder5", 1, 3'd5, 1, 5, 8, 2);
    do_roll("p2", 1, 3'd1, 2, 1, 1, 3);
    do_roll("six", 1, 3'd6, 3, 6, 6, 3);
    do_roll("wrap", 1, 3'd2, 3, 2, 8, 0);
    chk("keep.p0", pos_of(0), 22);
    chk("keep.p1", pos_of(1), 8);
    do_roll("p0b", 1, 3'd1, 0, 1, 23, 1);
    do_roll("ladder11", 1, 3'd3, 1, 3, 26, 2);

    // Snake at 27.
    do_reset();
    for (int k = 0; k < 4; k++)
      do_roll("run6a", 1, 3'd6, 0, 6, 6*(k+1), 0);
    do_roll("snake27", 1, 3'd3, 0, 3, 1, 1);

    // Overshoot, with and without a six.
    do_reset();
    for (int k = 0; k < 16; k++)
      do_roll("run6b", 1, 3'd6, 0, 6, 6*(k+1), 0);
    do_roll("to97", 1, 3'd1, 0, 1, 97, 1);
    do_roll("p1c", 1, 3'd1, 1, 1, 1, 2);
    do_roll("p2c", 1, 3'd1, 2, 1, 1, 3);
    do_roll("p3c", 1, 3'd1, 3, 1, 1, 0);
    do_roll("over6", 1, 3'd6, 0, 6, 97, 0);
    do_roll("over5", 1, 3'd5, 0, 5, 97, 1);

    // Win by exact landing.
    do_reset();
    do_roll("p0d", 1, 3'd1, 0, 1, 1, 1);
    do_roll("p1d", 1, 3'd1, 1, 1, 1, 2);
    for (int k = 0; k < 16; k++)
      do_roll("run6c", 1, 3'd6, 2, 6, 6*(k+1), 2);
    do_roll("win", 1, 3'd4, 2, 4, 100, -1);
    chk("win.over", 32'(game_over), 1);
    chk("win.id", 32'(winner_id), 2);
    roll = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("win.ignore_md", 32'(move_done), 0);
      chk("win.ready", 32'(roll_ready), 0);
    end
    roll = 1'b0;
    chk("win.pos_hold", pos_of(2), 100);
    chk("win.sticky", 32'(game_over), 1);

    // Out-of-range overrides fall back to the LFSR.
    do_reset();
    chk("clr.over", 32'(game_over), 0);
    do_roll("ovr7", 1, 3'd7, 0, -1, -1, -1);
    do_reset();
    do_roll("ovr0", 1, 3'd0, 0, -1, -1, -1);

    // Unforced rolls: every face appears, never 0 or 7.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      chk("lfsr.ready", 32'(roll_ready), 1);
      roll = 1'b1;
      @(negedge clk);
      roll = 1'b0;
      chk("lfsr.range",
          32'(dice_value >= 3'd1 && dice_value <= 3'd6), 1);
      if (dice_value >= 3'd1 && dice_value <= 3'd6)
        face_cnt[int'(dice_value)]++;
      repeat (2) @(negedge clk);
      if (game_over) do_reset();
    end
    for (int f = 1; f <= 6; f++)
      chk($sformatf("lfsr.face%0d", f), 32'(face_cnt[f] > 0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snl_game_engine.md
# snl_game_engine

Parametrised N-player Snakes and Ladders turn engine. It replaces the fixed two-player datapath with a single sequential core containing:
- an LFSR dice,
- a turn-rotation state machine,
- an exact-landing rule,
- a fixed snake/ladder jump table,
- a latched winner.

It sits between the board I/O (roll button debouncer, display driver) and the rest of the game logic. All player positions are exposed on one flat bus.

## Interface
Parameters:
- NUM_PLAYERS, 4, number of players (2..8); PID_W = max(1, clog2(NUM_PLAYERS))
- BOARD_MAX, 100, final square; exact landing required
- POS_W, 7, position width; must satisfy 2^POS_W > BOARD_MAX+6
- LFSR_SEED, 8'hA5, non-zero LFSR reset value

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- roll  in  1  roll request; accepted when roll && roll_ready at a rising edge
- roll_ready  out  1  engine idle and game not over
- dice_ovr_en  in  1  use dice_ovr instead of LFSR (test/demo mode)
- dice_ovr  in  3  forced dice value; honoured only if 1..6, otherwise LFSR value used
- dice_value  out  3  last accepted dice value (0 = none yet)
- active_player  out  PID_W  player whose turn it is
- move_done  out  1  one-cycle pulse: a move was committed
- move_player  out  PID_W  player moved by the last committed move
- positions  out  NUM_PLAYERS*POS_W  player p occupies bits [p*POS_W +: POS_W]
- game_over  out  1  sticky; set when a player reaches BOARD_MAX
- winner_id  out  PID_W  valid when game_over

## Operation
- Dice: 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every cycle, including while busy. Raw dice = (lfsr % 6) + 1, always 1..6.
- Move arithmetic:
  - sum = pos + dice, computed in POS_W+1 bits.
  - If sum > BOARD_MAX: the position is unchanged (overshoot, turn consumed).
  - Otherwise the jump table is applied to sum, once only; the jump result is never re-looked-up.
- Jump table, fixed:
  - Snakes: 27→1, 39→3, 51→19.
  - Ladders: 3→22, 5→8, 11→26.
  - Any other square maps to itself.
- Win: committed position == BOARD_MAX sets game_over and winner_id = mover. The engine then ignores roll until reset.
- Turn rotation after a commit:
  - Dice == 6 and no win: the same player rolls again.
  - Otherwise: active_player advances by 1, wrapping from NUM_PLAYERS-1 to 0.
  - An overshoot with a 6 still grants the extra turn.
- Players start at square 0. Square 0 is never a jump source.
- FSM states:
  - IDLE: roll_ready=1 unless game_over. roll → ROLLED.
  - ROLLED: unconditional → COMMIT.
  - COMMIT: unconditional → IDLE, or → OVER on a win.
  - OVER: absorbing until reset.

## Timing
- Edge k (roll accepted in IDLE):
  - dice_value registered (override or LFSR).
  - mover_id ← active_player.
  - state → ROLLED; roll_ready drops in cycle k+1.
- Edge k+1 (ROLLED):
  - Target position computed combinationally from registered dice_value and the mover's position.
  - Target registered into the commit stage.
  - state → COMMIT.
- Edge k+2 (COMMIT):
  - positions[mover] updated.
  - move_done=1 and move_player=mover for exactly cycle k+2.
  - active_player updated.
  - game_over/winner_id set if won.
  - state → IDLE/OVER; roll_ready=1 in cycle k+3 unless game_over.
- Latency: roll to committed position = 2 edges. Maximum throughput: one move per 3 cycles.
- roll asserted while roll_ready=0 is dropped, not queued. Holding roll high in IDLE produces back-to-back moves every 3 cycles.
- dice_ovr_en/dice_ovr are sampled only at the accepting edge.
- Reset values (immediate on assertion, mid-move included):
  - all positions 0, dice_value 0, active_player 0, move_player 0;
  - move_done 0, game_over 0, winner_id 0, roll_ready 0 while reset is high;
  - lfsr = LFSR_SEED, state IDLE.
  - A move in flight is discarded.

## Test plan
- Reset: assert reset mid-move (cycle k+1) → all positions 0, dice_value 0, no move_done pulse; roll_ready=1 on the first cycle after release.
- Ladder and rotation, NUM_PLAYERS=4: override 3 for P0 → P0 at 3→22; move_done pulse exactly 2 edges after accept; active_player=1. Then override 5 for P1 → P1 at 8.
- Extra turn and wrap: P3 rolls 6 → active_player stays 3. P3 then rolls 2 → active_player wraps to 0.
- Snake and overshoot: P0 positioned at 24, roll 3 → 27→1. P0 at 97 with override 5 → stays 97, move_done still pulses.
- Win: P2 at 96 with override 4 → position 100, game_over=1, winner_id=2. Further roll pulses → no move_done, roll_ready=0 until reset.
- LFSR and invalid override: dice_ovr_en=1, dice_ovr=7 → dice_value in 1..6 from LFSR. Over 600 unforced rolls every face 1..6 appears, and dice_value is never 0 or 7 after the first roll.
